mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage sitting directly downstream of the execute stage and upstream of write-back. It registers execute results, performs load/store transactions on the data bus through a request/grant/response FSM, and aligns and sign-extends load data. It presents forwarding information back to execute and hands completed instructions to write-back over a valid/ready handshake.

## Interface
- XLEN, 32: datapath width (from `defines.v`)
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_flush_i  in  1  kill the held instruction (trap/redirect)
- EX_valid_i / MEM_ready_o  in/out  1  upstream handshake
- MEM_valid_o / WB_ready_i  out/in  1  downstream handshake
- EX_pc_i  in  XLEN  instruction PC, passed through as MEM_pc_o
- EX_alu_res_i  in  XLEN  ALU result; the effective address for loads and stores
- EX_rs2_rdata_i  in  XLEN  store data
- EX_ld_st_info_i  in  LD_ST_INFO_WIDTH  {unsigned, size[1:0], store, load}
- EX_rd_wen_i, EX_rd_idx_i  in  1, 5  destination register
- EX_csr_wen_i, EX_csr_idx_i  in  1, 12  CSR write, passed through
- EX_excp_i  in  6  {mret, ebreak, ecall, ilegl_instr, if_bus_err, pc_misalign}, passed through
- dbus_req_o, dbus_we_o  out  1  bus request / write
- dbus_addr_o  out  XLEN  word-aligned address
- dbus_wdata_o, dbus_be_o  out  XLEN, 4  lane-aligned data, byte enables
- dbus_gnt_i, dbus_rvalid_i, dbus_err_i  in  1  grant, response valid, bus error
- dbus_rdata_i  in  XLEN  read data
- MEM_rd_wen_o, MEM_rd_idx_o, MEM_alu_res_o  out  1, 5, XLEN  forwarding to execute
- MEM_op_load_o  out  1  held instruction is a load; execute must not forward from it
- MEM_rd_wdata_o  out  XLEN  load data (extended) or ALU result
- MEM_ld_err_o, MEM_st_err_o  out  1  bus-error exceptions
- MEM_ld_misalign_o, MEM_st_misalign_o  out  1  present only with MEM_MISALIGN_EXCP_EN
- MEM_pc_o, MEM_csr_*_o, MEM_excp_o  out  registered pass-through

## Operation
- Data_valid register updates whenever MEM_ready_o is high: it loads EX_valid_i, and the payload is captured when EX_valid_i is also high. Instructions that are neither load nor store are captured with state DONE; loads and stores are captured with state REQ.
- MEM_ready_o = !data_valid || (MEM_valid_o && WB_ready_i). It is forced low in DRAIN.
- MEM_valid_o = data_valid && state==DONE && !mem_flush_i.
- FSM states are IDLE, REQ, WAIT, DONE and DRAIN.
  - REQ: dbus_req_o=1 with address, data and enables stable; on dbus_gnt_i go to WAIT.
  - WAIT: on dbus_rvalid_i, capture rdata and err, then go to DONE.
  - DONE: return to IDLE when handed off with no new capture; otherwise take the state of the new instruction.
- Byte enables: byte → 1<<addr[1:0]; half → 3<<addr[1]*2; word → 4'hF. Store data is replicated across lanes.
- Load extraction selects the lane by addr[1:0], then sign- or zero-extends per the unsigned bit.
- dbus_err_i sets MEM_ld_err_o or MEM_st_err_o. MEM_rd_wen_o is forced 0 on error.
- Flush behaviour:
  - In REQ before grant: the request drops next cycle and nothing is issued.
  - In WAIT: go to DRAIN, discard the response, then go to IDLE.
  - Otherwise: data_valid clears next cycle.
- All outputs are masked to 0 when data_valid=0.

## Timing
- Reset: all outputs 0, data_valid=0, state IDLE.
- Non-memory instruction: MEM_valid_o is high in the cycle after capture.
- Load or store with immediate grant and rvalid one cycle later: req in cycle 1, rvalid in cycle 2, MEM_valid_o in cycle 3.
- Grant arriving in the same cycle as rvalid is not supported; responses are in order, one outstanding.
- Forwarding outputs are valid from the cycle after capture, independent of FSM state.

## Configuration
- MEM_MISALIGN_EXCP_EN defined: a half access with addr[0]=1, or a word access with addr[1:0]≠0, skips the bus entirely (state DONE directly), sets the misalign output and clears rd_wen.
- Undefined: the misalign ports are absent and the address is truncated to natural alignment.

## Structure
- Package: LS_LOAD, LS_STORE, LS_SIZE_B/H/W, LS_UNSIGNED bit positions; LD_ST_INFO_WIDTH=5; FSM state encoding.
- Sub-module `lsu_align`: combinational byte-enable generation, store lane replication and load extraction/extension.

## Test plan
- ALU op, rd=x5, res=0x1234, WB_ready=1 → MEM_valid next cycle, rd_wdata=0x1234, no dbus_req.
- lb at 0x103, rdata=0x80FFFFFF, gnt immediate, rvalid next cycle → be=4'b1000, rd_wdata=0xFFFFFF80 in cycle 3; lbu → 0x00000080.
- sh at 0x202, data 0xABCD, gnt delayed 3 cycles → req held with addr 0x200, be=4'b1100, wdata=0xABCDABCD; MEM_ready_o low until done.
- Load in WAIT plus mem_flush_i → DRAIN; late rvalid discarded; MEM_valid never asserted for it.
- dbus_err_i on a load → MEM_ld_err_o=1, MEM_rd_wen_o=0; with MEM_MISALIGN_EXCP_EN, lw at 0x102 → misalign set, no req.
- rst asserted mid-WAIT → all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: load/store info bit layout and FSM encoding.
// Optional feature macro used by this slice: MEM_MISALIGN_EXCP_EN.
package mem_stage_pkg;

    localparam int XLEN             = 32;
    localparam int LD_ST_INFO_WIDTH = 5;

    // ld_st_info layout: {unsigned, size[1:0], store, load}
    localparam int LS_LOAD     = 0;
    localparam int LS_STORE    = 1;
    localparam int LS_SIZE_LSB = 2;
    localparam int LS_UNSIGNED = 4;

    localparam logic [1:0] LS_SIZE_B = 2'b00;
    localparam logic [1:0] LS_SIZE_H = 2'b01;
    localparam logic [1:0] LS_SIZE_W = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } mem_state_e;

    function automatic logic [1:0] ls_size(input logic [LD_ST_INFO_WIDTH-1:0] info);
        return info[LS_SIZE_LSB +: 2];
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication and load extraction/extension.
// Addresses are treated at natural alignment (low bits below the access size are ignored).
module lsu_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]      i_addr_lo,
    input  logic [1:0]      i_size,
    input  logic            i_unsigned,
    input  logic [XLEN-1:0] i_st_data,
    input  logic [XLEN-1:0] i_ld_raw,
    output logic [3:0]      o_be,
    output logic [XLEN-1:0] o_st_data,
    output logic [XLEN-1:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_ld_raw[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_ld_raw[31:16] : i_ld_raw[15:0];

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        o_be      = 4'hF;
        o_st_data = i_st_data;
        o_ld_data = i_ld_raw;
        case (i_size)
            LS_SIZE_B: begin
                o_be      = 4'b0001 << i_addr_lo;
                o_st_data = {4{i_st_data[7:0]}};
                o_ld_data = i_unsigned ? {{(XLEN-8){1'b0}}, w_byte}
                                       : {{(XLEN-8){w_byte[7]}}, w_byte};
            end
            LS_SIZE_H: begin
                o_be      = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_st_data = {2{i_st_data[15:0]}};
                o_ld_data = i_unsigned ? {{(XLEN-16){1'b0}}, w_half}
                                       : {{(XLEN-16){w_half[15]}}, w_half};
            end
            LS_SIZE_W: ;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers execute results, runs the data-bus request/grant/response
// FSM, aligns load data and hands off to write-back. Optional misalign traps: MEM_MISALIGN_EXCP_EN.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mem_flush_i,
    input  logic                        EX_valid_i,
    output logic                        MEM_ready_o,
    output logic                        MEM_valid_o,
    input  logic                        WB_ready_i,
    input  logic [XLEN-1:0]             EX_pc_i,
    input  logic [XLEN-1:0]             EX_alu_res_i,
    input  logic [XLEN-1:0]             EX_rs2_rdata_i,
    input  logic [LD_ST_INFO_WIDTH-1:0] EX_ld_st_info_i,
    input  logic                        EX_rd_wen_i,
    input  logic [4:0]                  EX_rd_idx_i,
    input  logic                        EX_csr_wen_i,
    input  logic [11:0]                 EX_csr_idx_i,
    input  logic [5:0]                  EX_excp_i,
    output logic                        dbus_req_o,
    output logic                        dbus_we_o,
    output logic [XLEN-1:0]             dbus_addr_o,
    output logic [XLEN-1:0]             dbus_wdata_o,
    output logic [3:0]                  dbus_be_o,
    input  logic                        dbus_gnt_i,
    input  logic                        dbus_rvalid_i,
    input  logic                        dbus_err_i,
    input  logic [XLEN-1:0]             dbus_rdata_i,
    output logic                        MEM_rd_wen_o,
    output logic [4:0]                  MEM_rd_idx_o,
    output logic [XLEN-1:0]             MEM_alu_res_o,
    output logic                        MEM_op_load_o,
    output logic [XLEN-1:0]             MEM_rd_wdata_o,
    output logic                        MEM_ld_err_o,
    output logic                        MEM_st_err_o,
`ifdef MEM_MISALIGN_EXCP_EN
    output logic                        MEM_ld_misalign_o,
    output logic                        MEM_st_misalign_o,
`endif
    output logic [XLEN-1:0]             MEM_pc_o,
    output logic                        MEM_csr_wen_o,
    output logic [11:0]                 MEM_csr_idx_o,
    output logic [5:0]                  MEM_excp_o
);

    logic                        r_valid;
    mem_state_e                  r_state;
    logic [XLEN-1:0]             r_pc;
    logic [XLEN-1:0]             r_alu_res;
    logic [XLEN-1:0]             r_rs2;
    logic [XLEN-1:0]             r_rdata;
    logic [LD_ST_INFO_WIDTH-1:0] r_info;
    logic                        r_rd_wen;
    logic [4:0]                  r_rd_idx;
    logic                        r_csr_wen;
    logic [11:0]                 r_csr_idx;
    logic [5:0]                  r_excp;
    logic                        r_err;

    logic                        w_is_mem;
    logic                        w_req;
    logic                        w_fault;
    mem_state_e                  w_capture_state;
    logic [3:0]                  w_be;
    logic [XLEN-1:0]             w_st_data;
    logic [XLEN-1:0]             w_ld_data;

    assign w_is_mem = EX_ld_st_info_i[LS_LOAD] | EX_ld_st_info_i[LS_STORE];

`ifdef MEM_MISALIGN_EXCP_EN
    logic r_misalign;
    logic w_misalign;
    logic [1:0] w_ex_size;

    assign w_ex_size  = ls_size(EX_ld_st_info_i);
    assign w_misalign = w_is_mem &&
                        ((w_ex_size == LS_SIZE_H && EX_alu_res_i[0]) ||
                         (w_ex_size == LS_SIZE_W && EX_alu_res_i[1:0] != 2'b00));
    // A misaligned access never touches the bus; it completes as a trap.
    assign w_capture_state   = (w_is_mem && !w_misalign) ? ST_REQ : ST_DONE;
    assign w_fault           = r_err | r_misalign;
    assign MEM_ld_misalign_o = r_valid && r_misalign && r_info[LS_LOAD];
    assign MEM_st_misalign_o = r_valid && r_misalign && r_info[LS_STORE];
`else
    assign w_capture_state = w_is_mem ? ST_REQ : ST_DONE;
    assign w_fault         = r_err;
`endif

    assign w_req       = r_valid && (r_state == ST_REQ);
    assign MEM_valid_o = r_valid && (r_state == ST_DONE) && !mem_flush_i;
    assign MEM_ready_o = (r_state != ST_DRAIN) && (!r_valid || (MEM_valid_o && WB_ready_i));

    lsu_align u_align (
        .i_addr_lo  (r_alu_res[1:0]),
        .i_size     (ls_size(r_info)),
        .i_unsigned (r_info[LS_UNSIGNED]),
        .i_st_data  (r_rs2),
        .i_ld_raw   (r_rdata),
        .o_be       (w_be),
        .o_st_data  (w_st_data),
        .o_ld_data  (w_ld_data)
    );

    assign dbus_req_o   = w_req;
    assign dbus_we_o    = w_req && r_info[LS_STORE];
    assign dbus_addr_o  = w_req ? {r_alu_res[XLEN-1:2], 2'b00} : '0;
    assign dbus_wdata_o = w_req ? w_st_data : '0;
    assign dbus_be_o    = w_req ? w_be : '0;

    // Forwarding fields are live as soon as the instruction is held, whatever the FSM is doing.
    assign MEM_rd_wen_o   = r_valid && r_rd_wen && !w_fault;
    assign MEM_rd_idx_o   = r_valid ? r_rd_idx : '0;
    assign MEM_alu_res_o  = r_valid ? r_alu_res : '0;
    assign MEM_op_load_o  = r_valid && r_info[LS_LOAD];
    assign MEM_rd_wdata_o = !r_valid ? '0 : (r_info[LS_LOAD] ? w_ld_data : r_alu_res);
    assign MEM_ld_err_o   = r_valid && r_err && r_info[LS_LOAD];
    assign MEM_st_err_o   = r_valid && r_err && r_info[LS_STORE];
    assign MEM_pc_o       = r_valid ? r_pc : '0;
    assign MEM_csr_wen_o  = r_valid && r_csr_wen;
    assign MEM_csr_idx_o  = r_valid ? r_csr_idx : '0;
    assign MEM_excp_o     = r_valid ? r_excp : '0;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_alu_res <= '0;
            r_rs2     <= '0;
            r_rdata   <= '0;
            r_info    <= '0;
            r_rd_wen  <= 1'b0;
            r_rd_idx  <= '0;
            r_csr_wen <= 1'b0;
            r_csr_idx <= '0;
            r_excp    <= '0;
            r_err     <= 1'b0;
`ifdef MEM_MISALIGN_EXCP_EN
            r_misalign <= 1'b0;
`endif
        end else if (MEM_ready_o) begin
            r_valid <= EX_valid_i;
            if (EX_valid_i) begin
                r_state   <= w_capture_state;
                r_pc      <= EX_pc_i;
                r_alu_res <= EX_alu_res_i;
                r_rs2     <= EX_rs2_rdata_i;
                r_rdata   <= '0;
                r_info    <= EX_ld_st_info_i;
                r_rd_wen  <= EX_rd_wen_i;
                r_rd_idx  <= EX_rd_idx_i;
                r_csr_wen <= EX_csr_wen_i;
                r_csr_idx <= EX_csr_idx_i;
                r_excp    <= EX_excp_i;
                r_err     <= 1'b0;
`ifdef MEM_MISALIGN_EXCP_EN
                r_misalign <= w_misalign;
`endif
            end else begin
                r_state <= ST_IDLE;
            end
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (mem_flush_i) begin
                        // A grant in the flush cycle means a response is still owed.
                        r_valid <= 1'b0;
                        r_state <= dbus_gnt_i ? ST_DRAIN : ST_IDLE;
                    end else if (dbus_gnt_i) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_flush_i) begin
                        r_valid <= 1'b0;
                        r_state <= dbus_rvalid_i ? ST_IDLE : ST_DRAIN;
                    end else if (dbus_rvalid_i) begin
                        r_rdata <= dbus_rdata_i;
                        r_err   <= dbus_err_i;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (mem_flush_i) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (dbus_rvalid_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized load/store traffic
// compared against an arithmetic model of lane selection, byte enables and extension.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_flush_i = 0;
    logic        EX_valid_i = 0;
    logic        MEM_ready_o, MEM_valid_o;
    logic        WB_ready_i = 1;
    logic [31:0] EX_pc_i = 0, EX_alu_res_i = 0, EX_rs2_rdata_i = 0;
    logic [4:0]  EX_ld_st_info_i = 0;
    logic        EX_rd_wen_i = 0;
    logic [4:0]  EX_rd_idx_i = 0;
    logic        EX_csr_wen_i = 0;
    logic [11:0] EX_csr_idx_i = 0;
    logic [5:0]  EX_excp_i = 0;
    logic        dbus_req_o, dbus_we_o;
    logic [31:0] dbus_addr_o, dbus_wdata_o;
    logic [3:0]  dbus_be_o;
    logic        dbus_gnt_i = 0, dbus_rvalid_i = 0, dbus_err_i = 0;
    logic [31:0] dbus_rdata_i = 0;
    logic        MEM_rd_wen_o;
    logic [4:0]  MEM_rd_idx_o;
    logic [31:0] MEM_alu_res_o;
    logic        MEM_op_load_o;
    logic [31:0] MEM_rd_wdata_o;
    logic        MEM_ld_err_o, MEM_st_err_o;
`ifdef MEM_MISALIGN_EXCP_EN
    logic        MEM_ld_misalign_o, MEM_st_misalign_o;
`endif
    logic [31:0] MEM_pc_o;
    logic        MEM_csr_wen_o;
    logic [11:0] MEM_csr_idx_o;
    logic [5:0]  MEM_excp_o;

    int checks = 0;
    int failures = 0;

    logic        e_csr_wen;
    logic [11:0] e_csr_idx;
    logic [5:0]  e_excp;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst), .mem_flush_i(mem_flush_i),
        .EX_valid_i(EX_valid_i), .MEM_ready_o(MEM_ready_o),
        .MEM_valid_o(MEM_valid_o), .WB_ready_i(WB_ready_i),
        .EX_pc_i(EX_pc_i), .EX_alu_res_i(EX_alu_res_i), .EX_rs2_rdata_i(EX_rs2_rdata_i),
        .EX_ld_st_info_i(EX_ld_st_info_i), .EX_rd_wen_i(EX_rd_wen_i), .EX_rd_idx_i(EX_rd_idx_i),
        .EX_csr_wen_i(EX_csr_wen_i), .EX_csr_idx_i(EX_csr_idx_i), .EX_excp_i(EX_excp_i),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_wdata_o(dbus_wdata_o), .dbus_be_o(dbus_be_o),
        .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i), .dbus_err_i(dbus_err_i),
        .dbus_rdata_i(dbus_rdata_i),
        .MEM_rd_wen_o(MEM_rd_wen_o), .MEM_rd_idx_o(MEM_rd_idx_o), .MEM_alu_res_o(MEM_alu_res_o),
        .MEM_op_load_o(MEM_op_load_o), .MEM_rd_wdata_o(MEM_rd_wdata_o),
        .MEM_ld_err_o(MEM_ld_err_o), .MEM_st_err_o(MEM_st_err_o),
`ifdef MEM_MISALIGN_EXCP_EN
        .MEM_ld_misalign_o(MEM_ld_misalign_o), .MEM_st_misalign_o(MEM_st_misalign_o),
`endif
        .MEM_pc_o(MEM_pc_o), .MEM_csr_wen_o(MEM_csr_wen_o), .MEM_csr_idx_o(MEM_csr_idx_o),
        .MEM_excp_o(MEM_excp_o)
    );

    logic [194:0] all_out;
    assign all_out = {MEM_valid_o, dbus_req_o, dbus_we_o, dbus_addr_o, dbus_wdata_o, dbus_be_o,
                      MEM_rd_wen_o, MEM_rd_idx_o, MEM_alu_res_o, MEM_op_load_o, MEM_rd_wdata_o,
                      MEM_ld_err_o, MEM_st_err_o, MEM_pc_o, MEM_csr_wen_o, MEM_csr_idx_o, MEM_excp_o};

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
        int a = int'(addr % 4);
        if (size == 2'd0) return 4'(1 << a);
        if (size == 2'd1) return 4'(3 << (2 * (a / 2)));
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] d);
        if (size == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (size == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [31:0] addr, input logic [31:0] rdata);
        int a = int'(addr % 4);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = (rdata >> (8 * a)) & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = (rdata >> (16 * (a / 2))) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    // Drive one instruction on the execute side; csr/excp fields are random pass-through values.
    task automatic put_ex(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2,
                          input logic [4:0] info, input logic rd_wen, input logic [4:0] rd);
        e_csr_wen = 1'($urandom_range(0, 1));
        e_csr_idx = 12'($urandom);
        e_excp    = 6'($urandom);
        EX_valid_i = 1; EX_pc_i = pc; EX_alu_res_i = alu; EX_rs2_rdata_i = rs2;
        EX_ld_st_info_i = info; EX_rd_wen_i = rd_wen; EX_rd_idx_i = rd;
        EX_csr_wen_i = e_csr_wen; EX_csr_idx_i = e_csr_idx; EX_excp_i = e_excp;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        checks++;
        if (all_out !== '0) begin
            failures++; $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        checks++;
        if (MEM_ready_o !== 1'b1) begin
            failures++; $display("FAIL reset_ready: got %b want 1", MEM_ready_o);
        end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_alu(input int n);
        logic [31:0] pc, res;
        logic [4:0]  rd, info;
        logic [91:0] got, exp;
        for (int i = 0; i < n; i++) begin
            pc   = $urandom;
            res  = (i == 0) ? 32'h1234 : $urandom;
            rd   = (i == 0) ? 5'd5 : 5'($urandom_range(1, 31));
            info = {3'($urandom), 2'b00};
            put_ex(pc, res, $urandom, info, 1'b1, rd);
            checks++;
            if (MEM_ready_o !== 1'b1) begin
                failures++; $display("FAIL alu_ready: got %b want 1", MEM_ready_o);
            end
            @(negedge clk);
            EX_valid_i = 0;
            got = {MEM_valid_o, dbus_req_o, MEM_op_load_o, MEM_rd_wen_o, MEM_rd_idx_o,
                   MEM_rd_wdata_o, MEM_pc_o, MEM_csr_wen_o, MEM_csr_idx_o, MEM_excp_o};
            exp = {1'b1, 1'b0, 1'b0, 1'b1, rd, res, pc, e_csr_wen, e_csr_idx, e_excp};
            checks++;
            if (got !== exp) begin
                failures++; $display("FAIL alu_result: got %h want %h", got, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        logic [31:0] res = $urandom;
        WB_ready_i = 0;
        put_ex($urandom, res, 0, 5'b0, 1'b1, 5'd7);
        @(negedge clk);
        EX_valid_i = 0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({MEM_valid_o, MEM_ready_o, MEM_rd_wdata_o} !== {1'b1, 1'b0, res}) begin
                failures++;
                $display("FAIL stall_hold: got %b/%b/%h want 1/0/%h", MEM_valid_o, MEM_ready_o, MEM_rd_wdata_o, res);
            end
            @(negedge clk);
        end
        WB_ready_i = 1;
        #1;
        checks++;
        if (MEM_ready_o !== 1'b1) begin
            failures++; $display("FAIL stall_release: got %b want 1", MEM_ready_o);
        end
        @(negedge clk);
        checks++;
        if (MEM_valid_o !== 1'b0) begin
            failures++; $display("FAIL stall_handoff: got %b want 0", MEM_valid_o);
        end
    endtask

    // Stream of ALU ops with random write-back back-pressure, tracked by a one-entry model.
    task automatic test_back_to_back(input int n);
        logic [31:0] items[$];
        logic [31:0] held_val = 0;
        bit held = 0;
        bit wb;
        int next = 0;
        int cyc = 0;
        for (int i = 0; i < n; i++) items.push_back($urandom);
        while ((next < n || held) && cyc < 200) begin
            wb = 1'($urandom_range(0, 1));
            WB_ready_i = wb;
            if (next < n) put_ex(32'(next), items[next], 0, 5'b0, 1'b1, 5'd9);
            else EX_valid_i = 0;
            #1;
            checks++;
            if ({MEM_valid_o, MEM_ready_o} !== {held, !held || wb}) begin
                failures++;
                $display("FAIL b2b_handshake: got %b%b want %b%b", MEM_valid_o, MEM_ready_o, held, !held || wb);
            end
            if (held) begin
                checks++;
                if (MEM_rd_wdata_o !== held_val) begin
                    failures++; $display("FAIL b2b_data: got %h want %h", MEM_rd_wdata_o, held_val);
                end
            end
            if ((!held || wb) && EX_valid_i) begin
                held = 1; held_val = items[next]; next++;
            end else if (held && wb) begin
                held = 0;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc >= 200) begin
            failures++; $display("FAIL b2b_timeout: got %0d cycles want <200", cyc);
        end
        EX_valid_i = 0;
        WB_ready_i = 1;
        @(negedge clk);
    endtask

    // One complete load/store with programmable grant and response latency.
    task automatic mem_txn(input string name, input logic [4:0] info, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [31:0] rdata,
                           input int gnt_dly, input int rsp_dly, input logic err);
        logic       ld = info[0];
        logic       st = info[1];
        logic [1:0] size = info[3:2];
        logic       uns = info[4];
        logic [4:0] rd = 5'($urandom_range(1, 31));
        logic [31:0] exp_wd;
        logic [70:0] got_req, exp_req;
        logic [40:0] got_fwd, exp_fwd;
        logic [36:0] got_done, exp_done;
        put_ex($urandom, addr, sdata, info, ld, rd);
        checks++;
        if (MEM_ready_o !== 1'b1) begin
            failures++; $display("FAIL %s_ready: got %b want 1", name, MEM_ready_o);
        end
        @(negedge clk);
        EX_valid_i = 0;
        exp_req = {1'b1, st, addr & 32'hFFFF_FFFC, model_be(size, addr), model_wdata(size, sdata), 1'b0};
        for (int c = 0; c <= gnt_dly; c++) begin
            got_req = {dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o, MEM_ready_o | MEM_valid_o};
            checks++;
            if (got_req !== exp_req) begin
                failures++; $display("FAIL %s_req: got %h want %h", name, got_req, exp_req);
            end
            if (c == gnt_dly) dbus_gnt_i = 1;
            @(negedge clk);
            dbus_gnt_i = 0;
        end
        exp_fwd = {1'b0, 1'b0, ld, ld, rd, addr};
        for (int c = 0; c <= rsp_dly; c++) begin
            got_fwd = {dbus_req_o, MEM_ready_o | MEM_valid_o, MEM_op_load_o, MEM_rd_wen_o, MEM_rd_idx_o, MEM_alu_res_o};
            checks++;
            if (got_fwd !== exp_fwd) begin
                failures++; $display("FAIL %s_wait: got %h want %h", name, got_fwd, exp_fwd);
            end
            if (c == rsp_dly) begin
                dbus_rvalid_i = 1; dbus_rdata_i = rdata; dbus_err_i = err;
            end
            @(negedge clk);
            dbus_rvalid_i = 0; dbus_err_i = 0; dbus_rdata_i = $urandom;
        end
        exp_wd = ld ? model_load(size, uns, addr, rdata) : addr;
        exp_done = {1'b1, exp_wd, ld & ~err, ld & err, st & err, 1'b0};
        got_done = {MEM_valid_o, MEM_rd_wdata_o, MEM_rd_wen_o, MEM_ld_err_o, MEM_st_err_o, dbus_req_o};
        checks++;
        if (got_done !== exp_done) begin
            failures++; $display("FAIL %s_done: got %h want %h", name, got_done, exp_done);
        end
        @(negedge clk);
        checks++;
        if ({MEM_valid_o, MEM_ready_o} !== 2'b01) begin
            failures++; $display("FAIL %s_handoff: got %b%b want 01", name, MEM_valid_o, MEM_ready_o);
        end
    endtask

    task automatic test_load_fixed();
        mem_txn("lb",  5'b0_00_01, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 0, 0, 1'b0);
        mem_txn("lbu", 5'b1_00_01, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 0, 0, 1'b0);
        mem_txn("lh",  5'b0_01_01, 32'h0000_0402, 32'h0, 32'h9234_5678, 1, 2, 1'b0);
        mem_txn("lw",  5'b0_10_01, 32'h0000_0800, 32'h0, 32'hDEAD_BEEF, 0, 1, 1'b0);
    endtask

    task automatic test_store_fixed();
        mem_txn("sh", 5'b0_01_10, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 3, 0, 1'b0);
        mem_txn("sb", 5'b0_00_10, 32'h0000_0301, 32'h1234_5699, 32'h0, 0, 0, 1'b0);
    endtask

    task automatic test_bus_err();
        mem_txn("lw_err", 5'b0_10_01, 32'h0000_1000, 32'h0, 32'h1111_2222, 0, 1, 1'b1);
        mem_txn("sw_err", 5'b0_10_10, 32'h0000_2000, 32'h5555_AAAA, 32'h0, 1, 0, 1'b1);
    endtask

    task automatic test_flush();
        // Flush while waiting for the response: drain, swallow the late response, never hand off.
        put_ex($urandom, 32'h0000_0104, 0, 5'b0_10_01, 1'b1, 5'd3);
        @(negedge clk);
        EX_valid_i = 0;
        dbus_gnt_i = 1;
        @(negedge clk);
        dbus_gnt_i = 0;
        mem_flush_i = 1;
        #1;
        checks++;
        if (MEM_valid_o !== 1'b0) begin
            failures++; $display("FAIL flush_wait_valid: got %b want 0", MEM_valid_o);
        end
        @(negedge clk);
        mem_flush_i = 0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({MEM_ready_o, all_out} !== '0) begin
                failures++; $display("FAIL flush_drain: got %b/%h want 0/0", MEM_ready_o, all_out);
            end
            if (c == 2) begin
                dbus_rvalid_i = 1; dbus_rdata_i = 32'hCAFE_F00D;
            end
            @(negedge clk);
            dbus_rvalid_i = 0;
        end
        checks++;
        if ({MEM_valid_o, MEM_ready_o} !== 2'b01) begin
            failures++; $display("FAIL flush_drain_exit: got %b%b want 01", MEM_valid_o, MEM_ready_o);
        end
        // Flush in REQ before any grant: request withdrawn next cycle.
        put_ex($urandom, 32'h0000_0300, 32'h77, 5'b0_00_10, 1'b0, 5'd0);
        @(negedge clk);
        EX_valid_i = 0;
        mem_flush_i = 1;
        @(negedge clk);
        mem_flush_i = 0;
        checks++;
        if ({dbus_req_o, MEM_valid_o, MEM_ready_o} !== 3'b001) begin
            failures++; $display("FAIL flush_req: got %b%b%b want 001", dbus_req_o, MEM_valid_o, MEM_ready_o);
        end
        // Flush of a completed instruction stalled by write-back.
        WB_ready_i = 0;
        put_ex($urandom, 32'h55, 0, 5'b0, 1'b1, 5'd4);
        @(negedge clk);
        EX_valid_i = 0;
        mem_flush_i = 1;
        #1;
        checks++;
        if (MEM_valid_o !== 1'b0) begin
            failures++; $display("FAIL flush_done_valid: got %b want 0", MEM_valid_o);
        end
        @(negedge clk);
        mem_flush_i = 0;
        WB_ready_i = 1;
        checks++;
        if ({all_out, MEM_ready_o} !== {195'b0, 1'b1}) begin
            failures++; $display("FAIL flush_done_clear: got %h/%b want 0/1", all_out, MEM_ready_o);
        end
    endtask

    task automatic test_reset_mid_wait();
        put_ex($urandom, 32'h0000_0600, 0, 5'b0_10_01, 1'b1, 5'd8);
        @(negedge clk);
        EX_valid_i = 0;
        dbus_gnt_i = 1;
        @(negedge clk);
        dbus_gnt_i = 0;
        rst = 1;
        #1;
        checks++;
        if ({all_out, MEM_ready_o} !== {195'b0, 1'b1}) begin
            failures++; $display("FAIL rst_wait: got %h/%b want 0/1", all_out, MEM_ready_o);
        end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        checks++;
        if ({all_out, MEM_ready_o} !== {195'b0, 1'b1}) begin
            failures++; $display("FAIL rst_idle: got %h/%b want 0/1", all_out, MEM_ready_o);
        end
    endtask

    task automatic test_random(input int n);
        logic [1:0]  size;
        logic [4:0]  info;
        logic [31:0] addr;
        bit          is_ld;
        for (int i = 0; i < n; i++) begin
            size  = 2'($urandom_range(0, 2));
            is_ld = 1'($urandom_range(0, 1));
            info  = {1'($urandom_range(0, 1)), size, !is_ld, is_ld};
            addr  = $urandom;
`ifdef MEM_MISALIGN_EXCP_EN
            if (size == 2'd1) addr[0] = 1'b0;
            if (size == 2'd2) addr[1:0] = 2'b00;
`endif
            mem_txn("rnd", info, addr, $urandom, $urandom, $urandom_range(0, 3),
                    $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
        end
    endtask

`ifdef MEM_MISALIGN_EXCP_EN
    task automatic test_misalign();
        put_ex($urandom, 32'h0000_0102, 0, 5'b0_10_01, 1'b1, 5'd6);
        @(negedge clk);
        EX_valid_i = 0;
        checks++;
        if ({MEM_valid_o, dbus_req_o, MEM_ld_misalign_o, MEM_st_misalign_o, MEM_rd_wen_o} !== 5'b10100) begin
            failures++; $display("FAIL misalign_lw: got %b%b%b%b%b want 10100", MEM_valid_o, dbus_req_o,
                                 MEM_ld_misalign_o, MEM_st_misalign_o, MEM_rd_wen_o);
        end
        @(negedge clk);
        put_ex($urandom, 32'h0000_0201, 32'h1, 5'b0_01_10, 1'b0, 5'd0);
        @(negedge clk);
        EX_valid_i = 0;
        checks++;
        if ({MEM_valid_o, dbus_req_o, MEM_ld_misalign_o, MEM_st_misalign_o} !== 4'b1001) begin
            failures++; $display("FAIL misalign_sh: got %b%b%b%b want 1001", MEM_valid_o, dbus_req_o,
                                 MEM_ld_misalign_o, MEM_st_misalign_o);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_alu(6);
        test_stall();
        test_back_to_back(10);
        test_load_fixed();
        test_store_fixed();
        test_bus_err();
        test_flush();
        test_reset_mid_wait();
        test_random(16);
`ifdef MEM_MISALIGN_EXCP_EN
        test_misalign();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
